// File: rtl/multi_servo_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : multi_servo_pwm
//  Function : NUM_CH hobby-servo PWM generators sharing one frame counter.
//             Per channel the target high time comes either from a signed
//             accelerometer sample (clamped and scaled) or from manual
//             inc/dec pulses. The applied duty slews toward the target and
//             only changes at the frame wrap, so frames are never truncated.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_servo_pwm #(
    parameter int NUM_CH    = 3,
    parameter int CLK_FREQ  = 25_000_000,
    parameter int PWM_FREQ  = 50,
    parameter int MIN_DC    = 25_000,
    parameter int MAX_DC    = 125_000,
    parameter int CENTER_DC = 75_000,
    parameter int ACC_RANGE = 2000,
    parameter int MAN_STEP  = 10_000,
    parameter int SLEW_STEP = 5_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 data_update,
    input  logic [NUM_CH*16-1:0] data_in,
    input  logic [NUM_CH-1:0]    mode,
    input  logic [NUM_CH-1:0]    inc,
    input  logic [NUM_CH-1:0]    dec,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [NUM_CH*20-1:0] duty_out,
    output logic                 frame_start
);

    localparam int                   c_PERIOD   = CLK_FREQ / PWM_FREQ;
    localparam int                   c_CNT_W    = $clog2(c_PERIOD);
    localparam logic [c_CNT_W-1:0]   c_LAST     = c_CNT_W'(c_PERIOD - 1);
    localparam logic [19:0]          c_CENTER   = 20'(CENTER_DC);
    localparam logic [19:0]          c_MIN      = 20'(MIN_DC);
    localparam logic [19:0]          c_MAX      = 20'(MAX_DC);
    localparam logic [19:0]          c_SLEW     = 20'(SLEW_STEP);
    localparam logic [19:0]          c_STEP     = 20'(MAN_STEP);
    localparam logic [20:0]          c_UP_LIM   = 21'(MAX_DC);
    localparam logic [20:0]          c_STEP_W   = 21'(MAN_STEP);
    localparam logic [20:0]          c_DN_LIM   = 21'(MIN_DC + MAN_STEP);
    localparam logic signed [16:0]   c_ACC_HI   = 17'(ACC_RANGE);
    localparam logic signed [16:0]   c_ACC_LO   = 17'(-ACC_RANGE);
    localparam logic signed [47:0]   c_SPAN     = 48'(MAX_DC - MIN_DC);
    localparam logic signed [47:0]   c_DIV      = 48'(2 * ACC_RANGE);
    localparam logic signed [47:0]   c_CENTER_S = 48'(CENTER_DC);
    localparam logic signed [47:0]   c_MIN_S    = 48'(MIN_DC);
    localparam logic signed [47:0]   c_MAX_S    = 48'(MAX_DC);

    logic [c_CNT_W-1:0] r_count;
    logic               w_wrap;

    assign w_wrap = (r_count == c_LAST);

    // Shared frame counter, 0..PERIOD-1.
    always_ff @(posedge clk) begin
        if (!reset_n)    r_count <= '0;
        else if (w_wrap) r_count <= '0;
        else             r_count <= r_count + c_CNT_W'(1);
    end

    // Gated by reset_n so the pulse is low in reset yet present on the very
    // first counter-zero cycle after release.
    assign frame_start = reset_n && (r_count == '0);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [15:0] w_sample;
        logic signed [16:0] w_clamped;
        logic signed [16:0] r_s1;
        logic               r_v1;
        logic signed [47:0] w_s1_ext;
        logic signed [47:0] w_scaled;
        logic [19:0]        w_acc_target;
        logic [20:0]        w_up_sum;
        logic [19:0]        w_man_up;
        logic [19:0]        w_man_dn;
        logic [19:0]        w_diff;
        logic [19:0]        w_slewed;
        logic [19:0]        r_target;
        logic [19:0]        r_duty;
        logic               r_mode_q;
        logic               r_pwm;
        logic               w_edge;
        logic               w_acc_mode;
        logic               w_man_mode;

        assign w_sample   = data_in[16*k +: 16];
        assign w_edge     = mode[k] ^ r_mode_q;
        assign w_acc_mode = ~mode[k] & ~r_mode_q;
        assign w_man_mode = mode[k] & r_mode_q;

        // Sign-extend the raw sample and clamp it to the accelerometer range.
        always_comb begin
            w_clamped = {w_sample[15], w_sample};
            if (w_clamped > c_ACC_HI)      w_clamped = c_ACC_HI;
            else if (w_clamped < c_ACC_LO) w_clamped = c_ACC_LO;
        end

        // Stage 1: capture the clamped sample; a newer strobe simply overwrites.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_s1 <= '0;
                r_v1 <= 1'b0;
            end else begin
                r_v1 <= data_update & w_acc_mode;
                if (data_update && w_acc_mode) r_s1 <= w_clamped;
            end
        end

        // Scale the captured sample around the centre (truncating division).
        always_comb begin
            w_s1_ext     = r_s1;
            w_scaled     = c_CENTER_S + (w_s1_ext * c_SPAN) / c_DIV;
            w_acc_target = w_scaled[19:0];
            if (w_scaled > c_MAX_S)      w_acc_target = c_MAX;
            else if (w_scaled < c_MIN_S) w_acc_target = c_MIN;
        end

        // Saturating manual step up and down from the current target.
        always_comb begin
            w_up_sum = {1'b0, r_target} + c_STEP_W;
            w_man_up = (w_up_sum > c_UP_LIM) ? c_MAX : w_up_sum[19:0];
            w_man_dn = ({1'b0, r_target} < c_DN_LIM) ? c_MIN : (r_target - c_STEP);
        end

        // Target register: a mode edge snaps to the applied duty (bumpless),
        // otherwise the settled mode decides the source.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_target <= c_CENTER;
            end else if (w_edge) begin
                r_target <= r_duty;
            end else if (w_man_mode) begin
                if (inc[k] && !dec[k])      r_target <= w_man_up;
                else if (dec[k] && !inc[k]) r_target <= w_man_dn;
            end else if (w_acc_mode && r_v1) begin
                r_target <= w_acc_target;
            end
        end

        // Previous mode, loaded in reset so releasing reset is not an edge.
        always_ff @(posedge clk) begin
            r_mode_q <= mode[k];
        end

        // Next duty: move toward the target by at most SLEW_STEP.
        always_comb begin
            if (r_target > r_duty) begin
                w_diff   = r_target - r_duty;
                w_slewed = r_duty + ((w_diff > c_SLEW) ? c_SLEW : w_diff);
            end else begin
                w_diff   = r_duty - r_target;
                w_slewed = r_duty - ((w_diff > c_SLEW) ? c_SLEW : w_diff);
            end
        end

        // Applied duty changes only at the frame wrap.
        always_ff @(posedge clk) begin
            if (!reset_n)    r_duty <= c_CENTER;
            else if (w_wrap) r_duty <= w_slewed;
        end

        // Registered PWM compare against the shared counter.
        always_ff @(posedge clk) begin
            if (!reset_n) r_pwm <= 1'b0;
            else          r_pwm <= (32'(r_count) < 32'(r_duty));
        end

        assign pwm_out[k]          = r_pwm;
        assign duty_out[20*k +: 20] = r_duty;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_servo_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_servo_pwm
//  Function : Directed self-checking bench for multi_servo_pwm, run with a
//             scaled-down frame (PERIOD = 500, duties 25..125) so that the
//             default-ratio arithmetic is kept while simulation stays short.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_servo_pwm;

    localparam int c_NUM_CH = 3;
    localparam int c_PERIOD = 500;

    typedef struct {
        logic [47:0] data;
        bit          upd;
        logic [2:0]  inc;
        logic [2:0]  dec;
        int          e0;
        int          e1;
        int          e2;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        data_update;
    logic [47:0] data_in;
    logic [2:0]  mode;
    logic [2:0]  inc;
    logic [2:0]  dec;
    logic [2:0]  pwm_out;
    logic [59:0] duty_out;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    vec_t vecs [25];

    multi_servo_pwm #(
        .NUM_CH   (c_NUM_CH),
        .CLK_FREQ (5000),
        .PWM_FREQ (10),
        .MIN_DC   (25),
        .MAX_DC   (125),
        .CENTER_DC(75),
        .ACC_RANGE(2000),
        .MAN_STEP (10),
        .SLEW_STEP(5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_update(data_update),
        .data_in    (data_in),
        .mode       (mode),
        .inc        (inc),
        .dec        (dec),
        .pwm_out    (pwm_out),
        .duty_out   (duty_out),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int duty_of(input int k);
        return int'(duty_out[20*k +: 20]);
    endfunction

    function automatic int tgt_of(input int k);
        case (k)
            0:       return int'(dut.g_ch[0].r_target);
            1:       return int'(dut.g_ch[1].r_target);
            default: return int'(dut.g_ch[2].r_target);
        endcase
    endfunction

    // Advance to the next negedge on which frame_start is high (bounded).
    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < c_PERIOD + 20 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got no frame_start expected one within %0d cycles", c_PERIOD + 20);
        end
    endtask

    // Reset for a few cycles with the given mode, release after a posedge.
    task automatic do_reset(input logic [2:0] m);
        @(posedge clk) #1;
        reset_n = 1'b0;
        mode    = m;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One-cycle accelerometer strobe.
    task automatic strobe(input logic [47:0] d);
        @(posedge clk) #1;
        data_in     = d;
        data_update = 1'b1;
        @(posedge clk) #1;
        data_update = 1'b0;
    endtask

    initial begin
        int highs [3];
        int fs_cnt;
        int e;

        vecs[0]  = '{{16'h1234, 16'h0000, 16'h0190}, 1'b1, 3'b000, 3'b000,  85,  75,  75};
        vecs[1]  = '{{16'h1234, 16'hF830, 16'h0BB8}, 1'b1, 3'b000, 3'b000, 125,  25,  75};
        vecs[2]  = '{{16'h0000, 16'hFE70, 16'hF830}, 1'b1, 3'b000, 3'b000,  25,  65,  75};
        vecs[3]  = '{{16'h0000, 16'h7FFF, 16'h8000}, 1'b1, 3'b000, 3'b000,  25, 125,  75};
        vecs[4]  = '{{16'h0000, 16'h0029, 16'hFFD7}, 1'b1, 3'b000, 3'b000,  74,  76,  75};
        vecs[5]  = '{{16'h0000, 16'hFFD9, 16'h0001}, 1'b1, 3'b000, 3'b000,  75,  75,  75};
        vecs[6]  = '{48'h0, 1'b0, 3'b111, 3'b000,  75,  75,  85};
        vecs[7]  = '{48'h0, 1'b0, 3'b100, 3'b000,  75,  75,  95};
        vecs[8]  = '{48'h0, 1'b0, 3'b100, 3'b000,  75,  75, 105};
        vecs[9]  = '{48'h0, 1'b0, 3'b100, 3'b000,  75,  75, 115};
        vecs[10] = '{48'h0, 1'b0, 3'b100, 3'b000,  75,  75, 125};
        vecs[11] = '{48'h0, 1'b0, 3'b100, 3'b000,  75,  75, 125};
        vecs[12] = '{48'h0, 1'b0, 3'b100, 3'b100,  75,  75, 125};
        vecs[13] = '{48'h0, 1'b0, 3'b000, 3'b100,  75,  75, 115};
        vecs[14] = '{48'h0, 1'b0, 3'b000, 3'b111,  75,  75, 105};
        vecs[15] = '{{16'h07D0, 16'h0000, 16'h0190}, 1'b1, 3'b000, 3'b000,  85,  75, 105};
        vecs[16] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  95};
        vecs[17] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  85};
        vecs[18] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  75};
        vecs[19] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  65};
        vecs[20] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  55};
        vecs[21] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  45};
        vecs[22] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  35};
        vecs[23] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  25};
        vecs[24] = '{48'h0, 1'b0, 3'b000, 3'b100,  85,  75,  25};

        reset_n     = 1'b0;
        data_update = 1'b0;
        data_in     = '0;
        mode        = 3'b000;
        inc         = 3'b000;
        dec         = 3'b000;

        // Reset state and the first frame after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_fs", int'(frame_start), 0);
        for (int k = 0; k < 3; k++) check($sformatf("rst_duty%0d", k), duty_of(k), 75);
        reset_n = 1'b1;
        @(negedge clk);
        check("first_fs", int'(frame_start), 1);

        // One full frame: 75 high cycles per channel, one frame_start per 500.
        for (int k = 0; k < 3; k++) highs[k] = 0;
        fs_cnt = 0;
        for (int i = 0; i < c_PERIOD; i++) begin
            for (int k = 0; k < 3; k++) if (pwm_out[k]) highs[k]++;
            if (frame_start) fs_cnt++;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) check($sformatf("idle_high%0d", k), highs[k], 75);
        check("fs_per_frame", fs_cnt, 1);
        check("fs_period", int'(frame_start), 1);

        // +400 -> target 85 exactly two cycles after the strobe, then slew.
        strobe({16'h0000, 16'h0000, 16'h0190});
        check("tgt_at_1", tgt_of(0), 75);
        @(posedge clk) #1;
        check("tgt_at_2", tgt_of(0), 85);
        wait_frame();
        check("duty_wrap1", duty_of(0), 80);
        wait_frame();
        check("duty_wrap2", duty_of(0), 85);
        check("duty_ch1_idle", duty_of(1), 75);

        // Back-to-back strobes: the later sample wins.
        @(posedge clk) #1;
        data_in     = {16'h0000, 16'h0000, 16'h0190};
        data_update = 1'b1;
        @(posedge clk) #1;
        data_in     = {16'h0000, 16'h0000, 16'hFE70};
        @(posedge clk) #1;
        data_update = 1'b0;
        @(posedge clk) #1;
        check("last_wins", tgt_of(0), 65);
        @(posedge clk) #1;
        check("last_wins_hold", tgt_of(0), 65);

        // Mid-frame reset with pwm high.
        wait_frame();
        check("pre_rst_duty", duty_of(0), 80);
        repeat (30) @(negedge clk);
        check("pre_rst_pwm", int'(pwm_out), 7);
        reset_n = 1'b0;
        @(posedge clk) #1;
        check("midrst_pwm", int'(pwm_out), 0);
        check("midrst_fs", int'(frame_start), 0);
        for (int k = 0; k < 3; k++) check($sformatf("midrst_duty%0d", k), duty_of(k), 75);

        // Table: ch0/ch1 accelerometer, ch2 manual.
        do_reset(3'b100);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk) #1;
            data_in     = vecs[i].data;
            data_update = vecs[i].upd;
            inc         = vecs[i].inc;
            dec         = vecs[i].dec;
            @(posedge clk) #1;
            data_update = 1'b0;
            inc         = 3'b000;
            dec         = 3'b000;
            @(posedge clk) #1;
            check($sformatf("vec%0d_t0", i), tgt_of(0), vecs[i].e0);
            check($sformatf("vec%0d_t1", i), tgt_of(1), vecs[i].e1);
            check($sformatf("vec%0d_t2", i), tgt_of(2), vecs[i].e2);
        end

        // Clamped +3000 ramps 75 -> 125 in ten wraps, then holds.
        do_reset(3'b000);
        strobe({16'h0000, 16'h0000, 16'h0BB8});
        for (int n = 1; n <= 11; n++) begin
            wait_frame();
            e = 75 + 5 * n;
            if (e > 125) e = 125;
            check($sformatf("ramp_wrap%0d", n), duty_of(0), e);
        end

        // Mode switch mid-ramp snaps target to the applied duty.
        do_reset(3'b000);
        strobe({16'h0000, 16'h0000, 16'h0BB8});
        repeat (4) wait_frame();
        check("sw_duty", duty_of(0), 95);
        check("sw_tgt_before", tgt_of(0), 125);
        @(posedge clk) #1;
        mode = 3'b001;
        @(posedge clk) #1;
        check("sw_tgt_snap", tgt_of(0), 95);
        wait_frame();
        check("sw_hold1", duty_of(0), 95);
        wait_frame();
        check("sw_hold2", duty_of(0), 95);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_servo_pwm.md
MULTI_SERVO_PWM -- requirements
Module: multi_servo_pwm

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of servo channels.
REQ-002 SHALL have parameter CLK_FREQ, default 25_000_000: clk frequency in Hz.
REQ-003 SHALL have parameter PWM_FREQ, default 50: frame rate; PERIOD = CLK_FREQ/PWM_FREQ (500_000).
REQ-004 SHALL have parameter MIN_DC, default 25_000: minimum high time in clk cycles.
REQ-005 SHALL have parameter MAX_DC, default 125_000: maximum high time in clk cycles.
REQ-006 SHALL have parameter CENTER_DC, default 75_000: reset and neutral high time.
REQ-007 SHALL have parameter ACC_RANGE, default 2000: accelerometer full-scale magnitude in LSB.
REQ-008 SHALL have parameter MAN_STEP, default 10_000: manual increment size.
REQ-009 SHALL have parameter SLEW_STEP, default 5_000: maximum duty change per frame.
REQ-010 SHALL have port clk, input, 1: single clock for all logic.
REQ-011 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-012 SHALL have port data_update, input, 1: one-cycle strobe; data_in valid.
REQ-013 SHALL have port data_in, input, NUM_CH*16: signed two's-complement samples; channel k at [16k+15:16k].
REQ-014 SHALL have port mode, input, NUM_CH: per channel, 0 = accelerometer, 1 = manual.
REQ-015 SHALL have port inc, input, NUM_CH: debounced one-cycle manual increment pulses.
REQ-016 SHALL have port dec, input, NUM_CH: debounced one-cycle manual decrement pulses.
REQ-017 SHALL have port pwm_out, output, NUM_CH: servo drive signals.
REQ-018 SHALL have port duty_out, output, NUM_CH*20: currently applied high time per channel.
REQ-019 SHALL have port frame_start, output, 1: one-cycle pulse when the period counter equals 0.

Function
REQ-020 SHALL run one shared period counter 0..PERIOD-1, incrementing every clk and wrapping to 0.
REQ-021 SHALL drive pwm_out[k] registered high when counter < duty_out[k], else low.
REQ-022 SHALL update duty_out only at the wrap cycle (counter = PERIOD-1), so no frame is truncated or glitched.
REQ-023 SHALL, at each wrap, move duty_out[k] toward target[k] by min(|target-duty|, SLEW_STEP).
REQ-024 SHALL, in accelerometer mode on data_update, sign-extend the sample and clamp it to [-ACC_RANGE, +ACC_RANGE].
REQ-025 SHALL compute target = CENTER_DC + clamped*(MAX_DC-MIN_DC)/(2*ACC_RANGE), with signed integer division truncating toward zero.
REQ-026 SHALL saturate target to [MIN_DC, MAX_DC].
REQ-027 SHALL register the new target exactly 2 clk cycles after data_update.
REQ-028 SHALL process a data_update arriving during that 2-cycle window with last-sample-wins semantics; no sample is mixed.
REQ-029 SHALL, in manual mode, ignore data_update for that channel.
REQ-030 SHALL, in manual mode, have inc add MAN_STEP and dec subtract MAN_STEP, each saturating at MAX_DC/MIN_DC.
REQ-031 SHALL leave the target unchanged when inc and dec are asserted in the same cycle.
REQ-032 SHALL ignore inc/dec in accelerometer mode.
REQ-033 SHALL make mode changes bumpless: on any mode edge, target[k] <= duty_out[k] in that cycle; the new mode takes effect the next cycle.
REQ-034 SHALL process channels independently; no channel's state affects another's.

Reset
REQ-035 SHALL, while reset_n = 0 at a clk edge, set counter = 0, target and duty_out = CENTER_DC, pwm_out = 0, and frame_start = 0.
REQ-036 SHALL, on a mid-frame reset, drive pwm_out low on the next cycle, then restart a full frame from counter 0 after release.
REQ-037 SHALL, after release, assert frame_start on the first cycle with counter = 0.

Verification
REQ-038 SHALL verify reset release with idle inputs -> pwm_out high 75_000 cycles per 500_000-cycle frame; frame_start period is 500_000.
REQ-039 SHALL verify accelerometer mode, data_in = +400 -> target 85_000 at +2 cycles; duty 80_000 after wrap 1 and 85_000 after wrap 2.
REQ-040 SHALL verify data_in = +3000 (clamped) -> target 125_000, reached after 10 wraps.
REQ-041 SHALL verify data_in = -2000 -> target 25_000.
REQ-042 SHALL verify data_in = 0xF830 (-2000) is treated as signed, not as 63536.
REQ-043 SHALL verify manual mode with duty 75_000: 3x inc -> target 105_000; 3 more inc -> 125_000 (saturated); inc+dec in the same cycle -> no change.
REQ-044 SHALL verify switching mode 0->1 while duty = 95_000 and target = 125_000 -> target snaps to 95_000 and duty holds 95_000 on following frames.
REQ-045 SHALL verify reset_n low at counter 30_000 with pwm_out high -> pwm_out low next cycle; duty_out = 75_000 across all channels.
